// File: rtl/im_req_pkg.sv
// Shared encodings, FSM state type and XY route helper for the IM request
// controller and its per-VC slices.
package im_req_pkg;

  localparam int NDIR = 5;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;
  localparam int DIR_L = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } req_st_t;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic logic [NDIR-1:0] xy_route(
    input int unsigned dst_x,
    input int unsigned dst_y,
    input int unsigned px,
    input int unsigned py
  );
    logic [NDIR-1:0] dir;
    dir = {NDIR{1'b0}};
    if (dst_x > px) begin
      dir[DIR_E] = 1'b1;
    end else if (dst_x < px) begin
      dir[DIR_W] = 1'b1;
    end else if (dst_y > py) begin
      dir[DIR_N] = 1'b1;
    end else if (dst_y < py) begin
      dir[DIR_S] = 1'b1;
    end else begin
      dir[DIR_L] = 1'b1;
    end
    return dir;
  endfunction

endpackage

// File: rtl/im_req_vc.sv
// One virtual circuit: IMa synchroniser, request FSM, route register and
// flit gating toward the crossbar.
module im_req_vc
  import im_req_pkg::*;
#(
  parameter int          AW = 4,
  parameter int          DW = 32,
  parameter int          SN = 5,
  parameter int unsigned PX = 0,
  parameter int unsigned PY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  input  logic [1:0]    in_ft,
  output logic          in_rdy,
  output logic [SN-1:0] IMr,
  input  logic          IMa,
  output logic          sw_vld,
  output logic [DW-1:0] sw_dat,
  output logic [1:0]    sw_ft,
  input  logic          sw_rdy,
  output logic          err
);

  req_st_t       state_r;
  req_st_t       nxt_state_s;
  logic [SN-1:0] imr_r;
  logic [SN-1:0] nxt_imr_s;
  logic [SN-1:0] route_s;
  logic          err_r;
  logic          nxt_err_s;
  logic          ima_meta_r;
  logic          ima_sync_r;

  assign route_s = xy_route(32'(in_dat[2*AW-1:AW]), 32'(in_dat[AW-1:0]), PX, PY);
  assign IMr     = imr_r;
  assign err     = err_r;
  assign sw_dat  = in_dat;
  assign sw_ft   = in_ft;

  // Two-flop synchroniser for the allocator acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ima_meta_r <= 1'b0;
      ima_sync_r <= 1'b0;
    end else begin
      ima_meta_r <= IMa;
      ima_sync_r <= ima_meta_r;
    end
  end

  // State, request and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      imr_r   <= {SN{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      imr_r   <= nxt_imr_s;
      err_r   <= nxt_err_s;
    end
  end

  // Next-state, request update and handshake gating
  always_comb begin
    nxt_state_s = state_r;
    nxt_imr_s   = imr_r;
    nxt_err_s   = err_r;
    in_rdy      = 1'b0;
    sw_vld      = 1'b0;
    if (rst) begin
      nxt_state_s = ST_IDLE;
      nxt_imr_s   = {SN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          nxt_imr_s = {SN{1'b0}};
          if (in_vld && in_ft[0]) begin
            // Head is held in the buffer; it is forwarded once granted.
            nxt_imr_s   = route_s;
            nxt_state_s = ST_REQ;
          end else if (in_vld) begin
            in_rdy    = 1'b1;
            nxt_err_s = 1'b1;
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (ima_sync_r) begin
            nxt_state_s = ST_XFER;
          end else begin
            nxt_state_s = ST_REQ;
          end
        end
        ST_XFER: begin
          sw_vld = in_vld;
          in_rdy = sw_rdy;
          // A falling ack here is a protocol violation and is ignored.
          if (in_vld && sw_rdy && in_ft[1]) begin
            nxt_imr_s   = {SN{1'b0}};
            nxt_state_s = ST_REL;
          end else begin
            nxt_state_s = ST_XFER;
          end
        end
        ST_REL: begin
          nxt_imr_s = {SN{1'b0}};
          if (!ima_sync_r) begin
            nxt_state_s = ST_IDLE;
          end else begin
            nxt_state_s = ST_REL;
          end
        end
        default: begin
          nxt_state_s = ST_IDLE;
          nxt_imr_s   = {SN{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/im_req_ctl.sv
// Per-input-port IM request controller: one independent request slice per
// virtual circuit, no state shared between them.
module im_req_ctl
  import im_req_pkg::*;
#(
  parameter int          VCN = 2,
  parameter int          SN  = 5,
  parameter int          AW  = 4,
  parameter int          DW  = 32,
  parameter int unsigned PX  = 0,
  parameter int unsigned PY  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VCN-1:0]          in_vld,
  input  logic [VCN-1:0][DW-1:0]  in_dat,
  input  logic [VCN-1:0][1:0]     in_ft,
  output logic [VCN-1:0]          in_rdy,
  output logic [VCN-1:0][SN-1:0]  IMr,
  input  logic [VCN-1:0]          IMa,
  output logic [VCN-1:0]          sw_vld,
  output logic [VCN-1:0][DW-1:0]  sw_dat,
  output logic [VCN-1:0][1:0]     sw_ft,
  input  logic [VCN-1:0]          sw_rdy,
  output logic [VCN-1:0]          err
);

  for (genvar v = 0; v < VCN; v++) begin : g_vc
    im_req_vc #(
      .AW(AW),
      .DW(DW),
      .SN(SN),
      .PX(PX),
      .PY(PY)
    ) u_vc (
      .clk   (clk),
      .rst   (rst),
      .in_vld(in_vld[v]),
      .in_dat(in_dat[v]),
      .in_ft (in_ft[v]),
      .in_rdy(in_rdy[v]),
      .IMr   (IMr[v]),
      .IMa   (IMa[v]),
      .sw_vld(sw_vld[v]),
      .sw_dat(sw_dat[v]),
      .sw_ft (sw_ft[v]),
      .sw_rdy(sw_rdy[v]),
      .err   (err[v])
    );
  end

endmodule

// File: tb/tb_im_req_ctl.sv
// Self-checking bench for im_req_ctl at router position (2,2): randomized
// flits and coordinates checked against a cycle-count protocol model.
module tb_im_req_ctl;

  localparam int          VCN = 2;
  localparam int          SN  = 5;
  localparam int          AW  = 4;
  localparam int          DW  = 32;
  localparam int unsigned PX  = 2;
  localparam int unsigned PY  = 2;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [VCN-1:0]          in_vld, in_rdy, IMa, sw_vld, sw_rdy, err;
  logic [VCN-1:0][DW-1:0]  in_dat, sw_dat;
  logic [VCN-1:0][1:0]     in_ft, sw_ft;
  logic [VCN-1:0][SN-1:0]  IMr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  im_req_ctl #(.VCN(VCN), .SN(SN), .AW(AW), .DW(DW), .PX(PX), .PY(PY)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_ft(in_ft),
    .in_rdy(in_rdy), .IMr(IMr), .IMa(IMa), .sw_vld(sw_vld), .sw_dat(sw_dat),
    .sw_ft(sw_ft), .sw_rdy(sw_rdy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference direction from the signed offset to the destination
  function automatic logic [SN-1:0] ref_route(input int x, input int y);
    int dx, dy, idx;
    dx = x - int'(PX);
    dy = y - int'(PY);
    if (dx != 0) idx = (dx > 0) ? 1 : 3;
    else if (dy != 0) idx = (dy > 0) ? 0 : 2;
    else idx = 4;
    return SN'(1) << idx;
  endfunction

  function automatic logic [DW-1:0] mk_dat(input int x, input int y);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[2*AW-1:AW] = AW'(x);
    d[AW-1:0] = AW'(y);
    return d;
  endfunction

  task automatic test_reset();
    in_vld = '0; in_dat = '0; in_ft = '0; IMa = '0; sw_rdy = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({IMr, in_rdy, sw_vld, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got IMr=%b in_rdy=%b sw_vld=%b err=%b, want all zero", IMr, in_rdy, sw_vld, err);
    end
    step();
    IMa = 2'b11;
    repeat (5) step();
    vectors++;
    if ({IMr, in_rdy, sw_vld, err} !== '0) begin
      miscompares++;
      $display("FAIL ack_without_head: got IMr=%b in_rdy=%b sw_vld=%b err=%b, want all zero", IMr, in_rdy, sw_vld, err);
    end
    IMa = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_route();
    int xs[5], ys[5];
    logic [SN-1:0] tab[5];
    logic [SN-1:0] exp;
    logic [DW-1:0] d;
    int x, y, vc, cnt;
    xs = '{3, 1, 2, 2, 2};
    ys = '{2, 2, 3, 0, 2};
    tab = '{5'b00010, 5'b01000, 5'b00001, 5'b00100, 5'b10000};
    for (int n = 0; n < 13; n++) begin
      vc = int'($urandom_range(0, 1));
      if (n < 5) begin
        x = xs[n]; y = ys[n]; exp = tab[n];
      end else begin
        x = int'($urandom_range(0, 15)); y = int'($urandom_range(0, 15)); exp = ref_route(x, y);
      end
      d = mk_dat(x, y);
      in_dat[vc] = d; in_ft[vc] = T_SGL; in_vld[vc] = 1'b1;
      step();
      vectors++;
      if (IMr[vc] !== exp) begin
        miscompares++;
        $display("FAIL route[%0d] vc%0d dst=(%0d,%0d): got %b, want %b", n, vc, x, y, IMr[vc], exp);
      end
      IMa[vc] = 1'b1; sw_rdy[vc] = 1'b1;
      cnt = 0;
      do begin step(); cnt++; end while (!sw_vld[vc] && cnt < 20);
      vectors++;
      if (cnt !== 3 || sw_dat[vc] !== d || in_rdy[vc] !== 1'b1) begin
        miscompares++;
        $display("FAIL route_xfer[%0d] vc%0d: got lat=%0d dat=%h rdy=%b, want lat=3 dat=%h rdy=1", n, vc, cnt, sw_dat[vc], in_rdy[vc], d);
      end
      step();
      vectors++;
      if (IMr[vc] !== '0) begin
        miscompares++;
        $display("FAIL route_release[%0d] vc%0d: got IMr=%b, want 0", n, vc, IMr[vc]);
      end
      in_vld[vc] = 1'b0; IMa[vc] = 1'b0; sw_rdy[vc] = 1'b0;
      repeat (4) step();
    end
  endtask

  task automatic test_packet();
    logic [DW-1:0] fd[4];
    logic [1:0] ftv[4];
    bit pat[5];
    logic [SN-1:0] exp;
    int vc, x, y, cnt, fi;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vc = int'($urandom_range(0, 1));
    x = int'($urandom_range(0, 15)); y = int'($urandom_range(0, 15));
    exp = ref_route(x, y);
    fd[0] = mk_dat(x, y);
    for (int i = 1; i < 4; i++) fd[i] = DW'($urandom);
    ftv = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
    in_dat[vc] = fd[0]; in_ft[vc] = ftv[0]; in_vld[vc] = 1'b1; sw_rdy[vc] = 1'b0;
    step();
    vectors++;
    if (IMr[vc] !== exp) begin
      miscompares++;
      $display("FAIL pkt_route vc%0d: got %b, want %b", vc, IMr[vc], exp);
    end
    for (int dly = 1; dly <= 5; dly++) begin
      step();
      vectors++;
      if ({in_rdy[vc], sw_vld[vc], IMr[vc]} !== {2'b00, exp}) begin
        miscompares++;
        $display("FAIL pkt_req_hold[%0d]: got rdy=%b vld=%b IMr=%b, want 0 0 %b", dly, in_rdy[vc], sw_vld[vc], IMr[vc], exp);
      end
    end
    IMa[vc] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[vc] && cnt < 20);
    vectors++;
    if (cnt !== 3) begin
      miscompares++;
      $display("FAIL pkt_xfer_latency vc%0d: got %0d cycles, want 3", vc, cnt);
    end
    fi = 0;
    for (int p = 0; p < 5; p++) begin
      sw_rdy[vc] = pat[p];
      #1;
      vectors++;
      if ({sw_vld[vc], in_rdy[vc], sw_ft[vc], sw_dat[vc]} !== {1'b1, pat[p], ftv[fi], fd[fi]}) begin
        miscompares++;
        $display("FAIL pkt_flit[%0d]: got vld=%b rdy=%b ft=%b dat=%h, want 1 %b %b %h", p, sw_vld[vc], in_rdy[vc], sw_ft[vc], sw_dat[vc], pat[p], ftv[fi], fd[fi]);
      end
      step();
      if (pat[p]) fi++;
      if (fi < 4) begin
        in_dat[vc] = fd[fi]; in_ft[vc] = ftv[fi];
        vectors++;
        if (IMr[vc] !== exp) begin
          miscompares++;
          $display("FAIL pkt_imr_hold[%0d]: got %b, want %b", p, IMr[vc], exp);
        end
      end
    end
    vectors++;
    if ({IMr[vc], in_rdy[vc], sw_vld[vc]} !== '0) begin
      miscompares++;
      $display("FAIL pkt_tail_release: got IMr=%b rdy=%b vld=%b, want 0", IMr[vc], in_rdy[vc], sw_vld[vc]);
    end
    // A stray body flit is presented so the first IDLE cycle is visible.
    in_dat[vc] = DW'($urandom); in_ft[vc] = T_BODY;
    IMa[vc] = 1'b0;
    cnt = 0;
    do begin step(); cnt++; end while (!in_rdy[vc] && cnt < 20);
    vectors++;
    if (cnt !== 3) begin
      miscompares++;
      $display("FAIL pkt_idle_latency vc%0d: got %0d cycles, want 3", vc, cnt);
    end
    step();
    in_vld[vc] = 1'b0; sw_rdy[vc] = 1'b0;
    vectors++;
    if (err[vc] !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_stray_err vc%0d: got %b, want 1", vc, err[vc]);
    end
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] da, db;
    logic [SN-1:0] ea, eb;
    int vc, cnt, hold, xb, yb;
    vc = int'($urandom_range(0, 1));
    da = mk_dat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    ea = ref_route(int'(da[2*AW-1:AW]), int'(da[AW-1:0]));
    xb = int'($urandom_range(0, 15)); yb = int'($urandom_range(0, 15));
    db = mk_dat(xb, yb); eb = ref_route(xb, yb);
    sw_rdy[vc] = 1'b1;
    in_dat[vc] = da; in_ft[vc] = T_SGL; in_vld[vc] = 1'b1;
    step();
    IMa[vc] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[vc] && cnt < 20);
    vectors++;
    if (cnt !== 3 || sw_dat[vc] !== da || IMr[vc] !== ea) begin
      miscompares++;
      $display("FAIL single_xfer vc%0d: got lat=%0d dat=%h IMr=%b, want 3 %h %b", vc, cnt, sw_dat[vc], IMr[vc], da, ea);
    end
    step();
    in_dat[vc] = db;
    hold = int'($urandom_range(2, 6));
    for (int i = 0; i < hold; i++) begin
      vectors++;
      if ({IMr[vc], in_rdy[vc], sw_vld[vc]} !== '0) begin
        miscompares++;
        $display("FAIL single_rel_wait[%0d]: got IMr=%b rdy=%b vld=%b, want 0", i, IMr[vc], in_rdy[vc], sw_vld[vc]);
      end
      step();
    end
    IMa[vc] = 1'b0;
    cnt = 0;
    do begin step(); cnt++; end while (IMr[vc] === '0 && cnt < 20);
    vectors++;
    if (cnt !== 4 || IMr[vc] !== eb) begin
      miscompares++;
      $display("FAIL single_rerequest vc%0d: got lat=%0d IMr=%b, want 4 %b", vc, cnt, IMr[vc], eb);
    end
    IMa[vc] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[vc] && cnt < 20);
    vectors++;
    if (cnt !== 3 || sw_dat[vc] !== db) begin
      miscompares++;
      $display("FAIL single_second vc%0d: got lat=%0d dat=%h, want 3 %h", vc, cnt, sw_dat[vc], db);
    end
    step();
    in_vld[vc] = 1'b0; IMa[vc] = 1'b0; sw_rdy[vc] = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_two_vc();
    logic [DW-1:0] d0, d1, t0;
    int cnt;
    d0 = mk_dat(3, 2); d1 = mk_dat(2, 2);
    in_dat[0] = d0; in_ft[0] = T_HEAD; in_dat[1] = d1; in_ft[1] = T_SGL;
    in_vld = 2'b11; sw_rdy = 2'b11;
    step();
    vectors++;
    if ({IMr[1], IMr[0]} !== {5'b10000, 5'b00010}) begin
      miscompares++;
      $display("FAIL two_vc_route: got %b %b, want 10000 00010", IMr[1], IMr[0]);
    end
    IMa[1] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[1] && cnt < 20);
    vectors++;
    if (cnt !== 3 || sw_dat[1] !== d1 || {sw_vld[0], in_rdy[0], IMr[0]} !== {2'b00, 5'b00010}) begin
      miscompares++;
      $display("FAIL two_vc_vc1_xfer: got lat=%0d dat=%h vc0=%b%b%b, want 3 %h 0000010", cnt, sw_dat[1], sw_vld[0], in_rdy[0], IMr[0], d1);
    end
    step();
    vectors++;
    if ({IMr[1], IMr[0]} !== {5'b00000, 5'b00010}) begin
      miscompares++;
      $display("FAIL two_vc_vc1_done: got %b %b, want 00000 00010", IMr[1], IMr[0]);
    end
    in_vld[1] = 1'b0; IMa[1] = 1'b0; IMa[0] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[0] && cnt < 20);
    vectors++;
    if (cnt !== 3 || sw_dat[0] !== d0 || sw_ft[0] !== T_HEAD || in_rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL two_vc_vc0_head: got lat=%0d dat=%h ft=%b rdy=%b, want 3 %h 01 1", cnt, sw_dat[0], sw_ft[0], in_rdy[0], d0);
    end
    step();
    t0 = DW'($urandom); in_dat[0] = t0; in_ft[0] = T_TAIL;
    #1;
    vectors++;
    if ({sw_dat[0], sw_ft[0], IMr[0]} !== {t0, T_TAIL, 5'b00010}) begin
      miscompares++;
      $display("FAIL two_vc_vc0_tail: got dat=%h ft=%b IMr=%b, want %h 10 00010", sw_dat[0], sw_ft[0], IMr[0], t0);
    end
    step();
    vectors++;
    if ({IMr, err} !== '0) begin
      miscompares++;
      $display("FAIL two_vc_end: got IMr=%b err=%b, want 0", IMr, err);
    end
    in_vld[0] = 1'b0; IMa[0] = 1'b0; sw_rdy = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_err_reset();
    int vc, ov, cnt;
    vc = int'($urandom_range(0, 1));
    ov = 1 - vc;
    rst = 1'b1; step(); rst = 1'b0; step();
    in_dat[vc] = DW'($urandom);
    in_ft[vc] = ($urandom_range(0, 1) == 0) ? T_BODY : T_TAIL;
    in_vld[vc] = 1'b1;
    #1;
    vectors++;
    if ({in_rdy[vc], err[vc]} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_consume vc%0d: got rdy=%b err=%b, want 1 0", vc, in_rdy[vc], err[vc]);
    end
    step();
    in_vld[vc] = 1'b0;
    repeat (3) step();
    vectors++;
    if ({err[vc], err[ov]} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_sticky vc%0d: got err=%b, want only vc%0d set", vc, err, vc);
    end
    in_dat[vc] = mk_dat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    in_ft[vc] = T_HEAD; in_vld[vc] = 1'b1;
    step();
    IMa[vc] = 1'b1; sw_rdy[vc] = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sw_vld[vc] && cnt < 20);
    step();
    in_dat[vc] = DW'($urandom); in_ft[vc] = T_BODY;
    vectors++;
    if (IMr[vc] === '0 || sw_vld[vc] !== 1'b1) begin
      miscompares++;
      $display("FAIL err_pre_reset vc%0d: got IMr=%b vld=%b, want request held in transfer", vc, IMr[vc], sw_vld[vc]);
    end
    #1 rst = 1'b1; IMa[vc] = 1'b0;
    #1;
    vectors++;
    if ({IMr, err, in_rdy, sw_vld} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got IMr=%b err=%b rdy=%b vld=%b, want 0", IMr, err, in_rdy, sw_vld);
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_rdy[vc], err[vc]} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_remainder vc%0d: got rdy=%b err=%b, want 1 0", vc, in_rdy[vc], err[vc]);
    end
    step();
    in_vld[vc] = 1'b0; sw_rdy[vc] = 1'b0;
    vectors++;
    if (err[vc] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_remainder_err vc%0d: got %b, want 1", vc, err[vc]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_route();
    test_single();
    test_two_vc();
    test_packet();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
